// File: rtl/hazard_forward_unit_pkg.sv
// hazard_forward_unit_pkg
//   Shared types for the hazard / forwarding unit:
//     REG_ADDR_W    - register address width used by the shadow slots
//     fwd_sel_t     - EX operand select code (register file, MEM/WB, EX/MEM)
//     shadow_slot_t - tracked pipeline slot {valid, rd, regwrite, memread}
//     fwd_pick()    - operand select from EX/MEM and MEM/WB hit flags
package hazard_forward_unit_pkg;

   localparam int unsigned REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_MEMWB = 2'b01,
      FWD_EXMEM = 2'b10
   } fwd_sel_t;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  regwrite;
      logic                  memread;
   } shadow_slot_t;

   // The younger producer (EX/MEM) holds the newer value, so it wins.
   function automatic fwd_sel_t fwd_pick(input logic exmem_hit, input logic memwb_hit);
      fwd_sel_t sel;
      if (exmem_hit) begin
         sel = FWD_EXMEM;
      end else if (memwb_hit) begin
         sel = FWD_MEMWB;
      end else begin
         sel = FWD_RF;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_forward_unit_match.sv
// hazard_match
//   Decides whether one tracked pipeline slot produces the value that one
//   source operand of the ID instruction needs.
//   Ports:
//     slot_valid, slot_regwrite - slot holds a real instruction that writes rd
//     slot_rd                   - destination register of the slot
//     src_addr, src_used        - source address and whether it is really read
//     match                     - slot result must be used for this source
module hazard_match #(
   parameter int unsigned ADDR_W = 5
) (
   input  logic              slot_valid,
   input  logic              slot_regwrite,
   input  logic [ADDR_W-1:0] slot_rd,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic              src_used,
   output logic              match
);

   // x0 is hard-wired to zero, so a write to it never creates a dependency.
   assign match = slot_valid && slot_regwrite && (slot_rd != '0) &&
                  (slot_rd == src_addr) && src_used;

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Load-use stall detection and EX operand forwarding for a 5-stage pipeline.
//   Keeps EX and MEM shadow slots of the instructions ahead of ID and
//   registers the forward select codes that the ID instruction will use in EX.
//   Ports:
//     clk, reset        - clock, synchronous active-high reset
//     hold              - global freeze; no internal state advances
//     ex_flush          - taken branch in EX, kills the ID instruction
//     id_*              - decoded fields of the instruction in ID
//     forward_a/b       - registered operand select for the EX instruction
//     stall             - load-use stall (combinational)
//     pc_write          - PC may update
//     if_id_write       - IF/ID may update
//     id_ex_bubble      - ID/EX loads a NOP this cycle
//     stall_count       - saturating stall-cycle counter (HAZ_STALL_CNT_EN only)
//   Optional feature macro: HAZ_STALL_CNT_EN.
//   REG_ADDR_W overrides must track hazard_forward_unit_pkg::REG_ADDR_W,
//   which sizes the shadow-slot rd field.
module hazard_forward_unit
   import hazard_forward_unit_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = hazard_forward_unit_pkg::REG_ADDR_W,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  hold,
   input  logic                  ex_flush,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_regwrite,
   input  logic                  id_memread,
   output logic [1:0]            forward_a,
   output logic [1:0]            forward_b,
   output logic                  stall,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  id_ex_bubble
`ifdef HAZ_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]      stall_count
`endif
);

   shadow_slot_t ex_q, ex_d;
   shadow_slot_t mem_q, mem_d;
   fwd_sel_t     fwd_a_q, fwd_a_d;
   fwd_sel_t     fwd_b_q, fwd_b_d;

   logic ex_rs1_hit, ex_rs2_hit;
   logic mem_rs1_hit, mem_rs2_hit;
   logic bubble_req;

   hazard_match #(.ADDR_W(REG_ADDR_W)) u_match_ex_rs1 (
      .slot_valid    (ex_q.valid),
      .slot_regwrite (ex_q.regwrite),
      .slot_rd       (ex_q.rd),
      .src_addr      (id_rs1),
      .src_used      (id_uses_rs1),
      .match         (ex_rs1_hit)
   );

   hazard_match #(.ADDR_W(REG_ADDR_W)) u_match_ex_rs2 (
      .slot_valid    (ex_q.valid),
      .slot_regwrite (ex_q.regwrite),
      .slot_rd       (ex_q.rd),
      .src_addr      (id_rs2),
      .src_used      (id_uses_rs2),
      .match         (ex_rs2_hit)
   );

   hazard_match #(.ADDR_W(REG_ADDR_W)) u_match_mem_rs1 (
      .slot_valid    (mem_q.valid),
      .slot_regwrite (mem_q.regwrite),
      .slot_rd       (mem_q.rd),
      .src_addr      (id_rs1),
      .src_used      (id_uses_rs1),
      .match         (mem_rs1_hit)
   );

   hazard_match #(.ADDR_W(REG_ADDR_W)) u_match_mem_rs2 (
      .slot_valid    (mem_q.valid),
      .slot_regwrite (mem_q.regwrite),
      .slot_rd       (mem_q.rd),
      .src_addr      (id_rs2),
      .src_used      (id_uses_rs2),
      .match         (mem_rs2_hit)
   );

   // A load in EX has no data until MEM, so a consumer in ID must wait once.
   // A flush kills the consumer anyway, so it suppresses the stall.
   assign stall = id_valid && !ex_flush && ex_q.memread && (ex_rs1_hit || ex_rs2_hit);

   assign bubble_req   = stall || ex_flush;
   assign pc_write     = !(stall || hold);
   assign if_id_write  = !(stall || hold);
   assign id_ex_bubble = bubble_req && !hold;

   assign forward_a = fwd_a_q;
   assign forward_b = fwd_b_q;

   always_comb begin
      ex_d    = ex_q;
      mem_d   = mem_q;
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
      if (!hold) begin
         mem_d = ex_q;
         if (bubble_req) begin
            ex_d    = '0;
            fwd_a_d = FWD_RF;
            fwd_b_d = FWD_RF;
         end else begin
            ex_d.valid    = id_valid;
            ex_d.rd       = id_rd;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
            fwd_a_d       = fwd_pick(ex_rs1_hit, mem_rs1_hit);
            fwd_b_d       = fwd_pick(ex_rs2_hit, mem_rs2_hit);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q    <= '0;
         mem_q   <= '0;
         fwd_a_q <= FWD_RF;
         fwd_b_q <= FWD_RF;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
      end
   end

   // Whether the MEM instruction was a load no longer matters for hazards.
   logic unused_mem_memread;
   assign unused_mem_memread = mem_q.memread;

`ifdef HAZ_STALL_CNT_EN
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   always_comb begin
      stall_count_d = stall_count_q;
      if (!hold && stall && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;
`else
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
`endif

endmodule
